// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the non-pipelined RV32I core: steps one instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath enables.
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       alu_out_we,
    output logic       reg_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       instr_retired,
    output logic       idle,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait;

    logic w_is_load, w_is_store, w_is_branch, w_legal, w_mem_phase, w_timeout;

    assign w_is_load   = (opcode == OP_LOAD);
    assign w_is_store  = (opcode == OP_STORE);
    assign w_is_branch = (opcode == OP_BRANCH);
    assign w_legal     = (opcode == OP_R)     || (opcode == OP_I)      || w_is_load  ||
                         w_is_store           || w_is_branch           ||
                         (opcode == OP_JAL)   || (opcode == OP_JALR)   ||
                         (opcode == OP_LUI)   || (opcode == OP_AUIPC);

    // Memory handshake: mem_req is held while in FETCH/MEM; the access completes in
    // the cycle mem_ready is high, and the FSM leaves the state on that edge.
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = (TIMEOUT_CYCLES > 0) && w_mem_phase && !mem_ready &&
                         (r_wait == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            if (TIMEOUT_CYCLES > 0 && w_mem_phase && !mem_ready) begin
                r_wait <= r_wait + CW'(1);
            end else begin
                r_wait <= '0;
            end
            case (r_state)
                S_IDLE:      if (run) r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)      r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_FAULT;
                end
                S_DECODE:    r_state <= w_legal ? S_EXECUTE : S_FAULT;
                S_EXECUTE: begin
                    if (w_is_load || w_is_store) r_state <= S_MEM;
                    else if (w_is_branch)        r_state <= run ? S_FETCH : S_IDLE;
                    else if (w_legal)            r_state <= S_WRITEBACK;
                    else                         r_state <= S_FAULT;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_load)       r_state <= S_WRITEBACK;
                        else if (w_is_store) r_state <= run ? S_FETCH : S_IDLE;
                        else                 r_state <= S_FAULT;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                    end
                end
                S_WRITEBACK: r_state <= run ? S_FETCH : S_IDLE;
                S_FAULT:     r_state <= S_FAULT;
                default:     r_state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_we         = 1'b0;
        alu_out_we    = 1'b0;
        reg_we        = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 2'b00;
        instr_retired = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXECUTE: begin
                alu_out_we = 1'b1;
                if (w_is_branch) begin
                    pc_we         = 1'b1;
                    pc_src        = branch_taken ? 2'b01 : 2'b00;
                    instr_retired = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                if (w_is_store && mem_ready) begin
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
            end
            S_WRITEBACK: begin
                reg_we        = 1'b1;
                pc_we         = 1'b1;
                instr_retired = 1'b1;
                if (opcode == OP_JAL)       pc_src = 2'b01;
                else if (opcode == OP_JALR) pc_src = 2'b10;
            end
            default: ;
        endcase
    end

    assign idle    = (r_state == S_IDLE);
    assign fault   = (r_state == S_FAULT) || (r_state == 3'd7);
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each instruction is expanded into its cycle-by-cycle
// output schedule, queued, and compared against the DUT on every cycle.
module tb_multicycle_sequencer;

    localparam int T = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst, run, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, alu_out_we, reg_we, pc_we;
    logic [1:0] pc_src;
    logic       instr_retired, idle, fault;
    logic [2:0] state_o;

    multicycle_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .alu_out_we(alu_out_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_src(pc_src), .instr_retired(instr_retired), .idle(idle),
        .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected vector: [15]=skip, [14:12]=state, then req,we,asel,ir,alu,reg,pcwe,src[2],ret,idle,fault
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          lat_cnt = 0;
    int          last_lat = 0;
    logic        m_idle = 1'b1;
    logic [6:0]  legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    function automatic logic [15:0] V(input int st, input logic req, input logic we,
                                      input logic asel, input logic irwe, input logic aluwe,
                                      input logic regwe, input logic pcwe,
                                      input logic [1:0] src, input logic ret);
        return {1'b0, 3'(st), req, we, asel, irwe, aluwe, regwe, pcwe, src, ret,
                (st == 0), (st == 6)};
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic step(input logic rs, input logic r, input logic [6:0] o,
                        input logic b, input logic mr, input logic [15:0] e);
        @(negedge clk);
        rst = rs; run = r; opcode = o; branch_taken = b; mem_ready = mr;
        exp_q.push_back(e);
    endtask

    initial begin : compare
        logic [15:0] act, e;
        forever begin
            @(negedge clk);
            #2;
            act = {1'b0, state_o, mem_req, mem_we, mem_addr_sel, ir_we, alu_out_we,
                   reg_we, pc_we, pc_src, instr_retired, idle, fault};
            if (idle === 1'b1) lat_cnt = 0;
            else if (instr_retired === 1'b1) begin
                last_lat = lat_cnt + 1;
                lat_cnt  = 0;
            end else lat_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e[15]) begin
                    total++;
                    if (act !== e) begin
                        bad++;
                        $display("FAIL outputs t=%0t act=%h exp=%h", $time, act, e);
                    end
                    total++;
                    if ((ir_we & reg_we) !== 1'b0) begin
                        bad++;
                        $display("FAIL ir_reg_exclusive t=%0t act=%b exp=0", $time,
                                 ir_we & reg_we);
                    end
                end
            end
        end
    end

    task automatic chk_lat(input int expv, input string name);
        #3;
        total++;
        if (last_lat != expv) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, last_lat, expv);
        end
    endtask

    task automatic do_reset();
        step(1'b1, rb(), ro(), rb(), rb(), 16'h8000);
        m_idle = 1'b1;
    endtask

    task automatic from_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ro(), rb(), rb(), V(0,0,0,0,0,0,0,0,2'b00,0));
        step(1'b0, 1'b1, ro(), rb(), rb(), V(0,0,0,0,0,0,0,0,2'b00,0));
        m_idle = 1'b0;
    endtask

    task automatic fault_hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rb(), ro(), rb(), rb(), V(6,0,0,0,0,0,0,0,2'b00,0));
    endtask

    // One instruction: fw/mw are the non-ready cycles in FETCH/MEM; run_end is run at retire.
    task automatic instr(input logic [6:0] opc, input int fw, input int mw, input logic bt,
                         input logic run_end, output logic faulted);
        logic ld, st;
        logic [1:0] src;
        faulted = 1'b0;
        if (m_idle) from_idle(int'($urandom_range(0, 2)));
        ld = (opc == OP_LOAD);
        st = (opc == OP_STORE);
        for (int i = 0; i < fw; i++) begin
            step(1'b0, rb(), ro(), rb(), 1'b0, V(1,1,0,0,0,0,0,0,2'b00,0));
            if (i == T - 1) begin faulted = 1'b1; return; end
        end
        step(1'b0, rb(), ro(), rb(), 1'b1, V(1,1,0,0,1,0,0,0,2'b00,0));
        step(1'b0, rb(), opc, rb(), rb(), V(2,0,0,0,0,0,0,0,2'b00,0));
        if (!is_legal(opc)) begin faulted = 1'b1; return; end
        if (opc == OP_BRANCH) begin
            step(1'b0, run_end, opc, bt, rb(), V(3,0,0,0,0,1,0,1,{1'b0, bt},1));
            m_idle = !run_end;
            return;
        end
        step(1'b0, rb(), opc, rb(), rb(), V(3,0,0,0,0,1,0,0,2'b00,0));
        if (ld || st) begin
            for (int i = 0; i < mw; i++) begin
                step(1'b0, rb(), opc, rb(), 1'b0, V(4,1,st,1,0,0,0,0,2'b00,0));
                if (i == T - 1) begin faulted = 1'b1; return; end
            end
            if (st) begin
                step(1'b0, run_end, opc, rb(), 1'b1, V(4,1,1,1,0,0,0,1,2'b00,1));
                m_idle = !run_end;
                return;
            end
            step(1'b0, rb(), opc, rb(), 1'b1, V(4,1,0,1,0,0,0,0,2'b00,0));
        end
        src = (opc == OP_JAL) ? 2'b01 : (opc == OP_JALR) ? 2'b10 : 2'b00;
        step(1'b0, run_end, opc, rb(), rb(), V(5,0,0,0,0,0,1,1,src,1));
        m_idle = !run_end;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic f;
        logic [6:0] o;
        int fw, mw;
        rst = 1'b1; run = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
        do_reset();
        instr(OP_R, 0, 0, 0, 1, f);        chk_lat(4, "r_lat0");
        instr(OP_R, 0, 0, 0, 1, f);        chk_lat(4, "r_lat1");
        instr(OP_R, 0, 0, 0, 1, f);        chk_lat(4, "r_lat2");
        instr(OP_LOAD, 0, 3, 0, 1, f);     chk_lat(8, "load_wait3_lat");
        instr(OP_STORE, 0, 0, 0, 1, f);    chk_lat(4, "store_lat");
        instr(OP_BRANCH, 0, 0, 1, 1, f);   chk_lat(3, "branch_taken_lat");
        instr(OP_BRANCH, 0, 0, 0, 1, f);   chk_lat(3, "branch_not_taken_lat");
        instr(OP_JAL, 0, 0, 0, 1, f);      chk_lat(4, "jal_lat");
        instr(OP_JALR, 0, 0, 0, 1, f);     chk_lat(4, "jalr_lat");
        instr(OP_LOAD, 0, 0, 0, 1, f);     chk_lat(5, "load_lat");
        instr(OP_R, 15, 0, 0, 1, f);       chk_lat(19, "fetch_ready_on_last_lat");
        instr(OP_R, 0, 0, 0, 0, f);        chk_lat(4, "add_run_low_lat");
        from_idle(6);

        // Reset while a LOAD waits in MEM, with mem_ready high in the reset cycle.
        step(1'b0, rb(), ro(), rb(), 1'b1, V(1,1,0,0,1,0,0,0,2'b00,0));
        step(1'b0, rb(), OP_LOAD, rb(), rb(), V(2,0,0,0,0,0,0,0,2'b00,0));
        step(1'b0, rb(), OP_LOAD, rb(), rb(), V(3,0,0,0,0,1,0,0,2'b00,0));
        step(1'b0, rb(), OP_LOAD, rb(), 1'b0, V(4,1,0,1,0,0,0,0,2'b00,0));
        step(1'b1, rb(), OP_LOAD, rb(), 1'b1, V(4,1,0,1,0,0,0,0,2'b00,0));
        step(1'b0, 1'b0, OP_LOAD, rb(), rb(), V(0,0,0,0,0,0,0,0,2'b00,0));
        m_idle = 1'b1;

        instr(7'b0000000, 0, 0, 0, 1, f);  fault_hold(5); do_reset();
        instr(OP_R, 16, 0, 0, 1, f);       fault_hold(5); do_reset();
        instr(OP_LOAD, 0, 16, 0, 1, f);    fault_hold(3); do_reset();
        instr(OP_STORE, 0, 15, 0, 1, f);   chk_lat(19, "store_ready_on_last_lat");

        repeat (200) begin
            if ($urandom_range(0, 19) == 0) begin
                o = ro();
                if (is_legal(o)) o = 7'b1111111;
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
            end
            fw = ($urandom_range(0, 12) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 12) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            instr(o, fw, mw, rb(), ($urandom_range(0, 3) != 0), f);
            if (f) begin
                fault_hold(int'($urandom_range(1, 4)));
                do_reset();
            end
        end
        step(1'b0, 1'b0, ro(), rb(), rb(), 16'h8000);
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM that sequences the shared single-port memory, instruction register, ALU output register, register file write and PC update for one RV32I instruction at a time.
Consumes the opcode of the latched instruction and a branch-taken flag from the comparator.
Produces per-cycle enables and select lines for the datapath, plus status outputs (idle, fault, retire).
Sits between the instruction decoder and the datapath muxes/registers in the non-pipelined core variant.

Parameters:
TIMEOUT_CYCLES, 16, consecutive cycles without mem_ready in FETCH/MEM before entering FAULT; 0 disables timeout.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
run  input  1  permit starting a new instruction
opcode  input  7  opcode field of the instruction register
branch_taken  input  1  branch comparator result, valid in EXECUTE
mem_ready  input  1  memory accepted/completed the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write (store)
mem_addr_sel  output  1  0: PC, 1: ALU output register
ir_we  output  1  load instruction register
alu_out_we  output  1  load ALU output register
reg_we  output  1  register file write enable
pc_we  output  1  PC write enable
pc_src  output  2  00: PC+4, 01: PC+imm (branch/jal), 10: ALU output & ~1 (jalr)
instr_retired  output  1  one-cycle pulse when an instruction completes
idle  output  1  FSM in IDLE
fault  output  1  FSM in FAULT (sticky)
state_o  output  3  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, FAULT=6. Encoding 7 is unreachable; if reached, go to FAULT.
- Reset: rst sampled high on a rising edge forces IDLE and clears the wait counter. rst overrides every other input, including a pending mem_ready.
  - After reset all outputs are 0 except idle=1 and state_o=0.
  - Reset in the middle of an instruction abandons it; no pc_we or reg_we is issued.
- All outputs are decoded combinationally from the current state, opcode, branch_taken and mem_ready. Registered elements are the state and the wait counter only.
- Legal opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI), 0010111 (AUIPC).
- IDLE: if run=1, go to FETCH; otherwise stay in IDLE.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0.
  - If mem_ready=1: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no enables asserted.
  - Illegal opcode: go to FAULT.
  - Legal opcode: go to EXECUTE.
- EXECUTE: alu_out_we=1. Next state by opcode:
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_we=1, pc_src=01 if branch_taken else 00, instr_retired=1, then go to FETCH if run=1, else IDLE.
  - Other legal opcodes: go to WRITEBACK.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only. Stay until mem_ready=1, then:
  - LOAD: go to WRITEBACK.
  - STORE: pc_we=1, pc_src=00, instr_retired=1, then go to FETCH if run=1, else IDLE.
- WRITEBACK: reg_we=1, pc_we=1, instr_retired=1.
  - pc_src=01 for JAL, 10 for JALR, 00 otherwise.
  - Then go to FETCH if run=1, else IDLE.
- run is sampled only at instruction boundaries. Deasserting run mid-instruction lets the instruction complete, then the FSM enters IDLE.
- Wait counter and timeout:
  - The counter clears on entry to FETCH or MEM and whenever mem_ready=1.
  - It increments on each FETCH/MEM cycle with mem_ready=0.
  - When TIMEOUT_CYCLES>0 and the TIMEOUT_CYCLES-th consecutive non-ready cycle occurs, go to FAULT next cycle. mem_req drops there.
  - mem_ready on exactly the last permitted cycle wins over timeout.
  - Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1; no wrap is possible.
- FAULT: all enables 0, fault=1. Only rst exits FAULT.
- Latencies with zero-wait memory (cycles from leaving IDLE/previous retire to retire):
  - R/I-ALU/LUI/AUIPC/JAL/JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each added memory wait cycle adds 1.
- Invariant: at most one of ir_we, reg_we is high in any cycle.

Test Plan:
- Reset then run=1, mem_ready=1 constantly, opcode=0110011. Required: state sequence 1,2,3,5,1; reg_we and pc_we high only in WRITEBACK with pc_src=00; instr_retired every 4 cycles.
- LOAD (0000011) with mem_ready low for 3 cycles in MEM. Required: mem_req=1, mem_addr_sel=1, mem_we=0 held for 4 cycles; WRITEBACK follows; retire 8 cycles after FETCH entry.
- STORE, then BRANCH with branch_taken=1, then BRANCH with branch_taken=0.
  - STORE: mem_we=1 in MEM; retires from MEM with pc_src=00.
  - Taken BRANCH: pc_src=01 in EXECUTE.
  - Not-taken BRANCH: pc_src=00.
  - No reg_we for any of the three.
- JAL then JALR. Required: WRITEBACK shows reg_we=1 with pc_src=01, then pc_src=10.
- TIMEOUT_CYCLES=16, mem_ready held 0 in FETCH.
  - fault=1 after 16 wait cycles and stays 1; mem_req=0 in FAULT.
  - Separate run: mem_ready=1 on the 16th cycle gives a normal DECODE.
  - Opcode 0000000 in DECODE gives FAULT.
- rst asserted during MEM of a LOAD: next cycle idle=1 and all enables 0, with no reg_we or pc_we. Deassert run before WRITEBACK of an ADD: the ADD retires, then the FSM enters IDLE and stays there.
